ctl_sequencer: RTL and testbench

Microsequencer that drives the control side of the ALU datapath. It accepts encoded micro-instructions over a valid/ready handshake and decodes each into a two-phase control sequence on the register-file control buses: a read phase that selects the source onto the S-bus, then a write-back phase that commits the ALU result into the destination register. It sits between the instruction source and the register file/ALU, and it is the only block that drives `ctl_dest`, `ctl_sbus`, `ctl_address` and `ctl_alu`.

---
 rtl/globals.sv | 55 +++++
 rtl/ctl_sequencer.sv | 122 ++++++++++++
 tb/tb_ctl_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/globals.sv
// Shared constants for the ALU datapath control side: register/S-bus select
// codes, micro-instruction opcodes and field positions, sequencer state type.
package globals;

    localparam int WORDLEN = 16;

    localparam logic [3:0] DST_R0   = 4'd0;
    localparam logic [3:0] DST_R1   = 4'd1;
    localparam logic [3:0] DST_R2   = 4'd2;
    localparam logic [3:0] DST_R3   = 4'd3;
    localparam logic [3:0] DST_R4   = 4'd4;
    localparam logic [3:0] DST_R5   = 4'd5;
    localparam logic [3:0] DST_R6   = 4'd6;
    localparam logic [3:0] DST_R7   = 4'd7;
    localparam logic [3:0] DST_NONE = 4'hF;

    localparam logic [3:0] SBUS_R0       = 4'd0;
    localparam logic [3:0] SBUS_R1       = 4'd1;
    localparam logic [3:0] SBUS_R2       = 4'd2;
    localparam logic [3:0] SBUS_R3       = 4'd3;
    localparam logic [3:0] SBUS_R4       = 4'd4;
    localparam logic [3:0] SBUS_R5       = 4'd5;
    localparam logic [3:0] SBUS_R6       = 4'd6;
    localparam logic [3:0] SBUS_R7       = 4'd7;
    localparam logic [3:0] SBUS_ADDCONST = 4'h8;
    localparam logic [3:0] SBUS_NONE     = 4'hF;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_LDC = 4'd2;
    localparam logic [3:0] OP_REP = 4'd15;

    localparam int OPC_HI   = 23;
    localparam int OPC_LO   = 20;
    localparam int DEST_HI  = 19;
    localparam int DEST_LO  = 16;
    localparam int SRC_HI   = 15;
    localparam int SRC_LO   = 12;
    localparam int CONST_HI = 11;
    localparam int CONST_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  sbus;
        logic [3:0]  alu;
        logic [11:0] address;
    } ctl_t;

endpackage

// File: rtl/ctl_sequencer.sv
// Microsequencer: turns each accepted micro-instruction into a READ then
// WRITE control pass on the register-file buses, with optional repeat.
module ctl_sequencer
    import globals::*;
#(
    parameter int INSTR_W = 24,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [3:0]         ctl_dest,
    output logic [3:0]         ctl_sbus,
    output logic [11:0]        ctl_address,
    output logic [3:0]         ctl_alu,
    output logic               busy,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    // Illegal register fields collapse to the NONE codes so nothing is written/read.
    function automatic ctl_t decode(input logic [INSTR_W-1:0] instr);
        ctl_t       d;
        logic [3:0] op;
        logic [3:0] dst;
        logic [3:0] src;
        op        = instr[OPC_HI:OPC_LO];
        dst       = instr[DEST_HI:DEST_LO];
        src       = instr[SRC_HI:SRC_LO];
        d.alu     = op;
        d.address = instr[CONST_HI:CONST_LO];
        d.dest    = dst[3] ? DST_NONE : dst;
        if (op == OP_LDC)
            d.sbus = SBUS_ADDCONST;
        else
            d.sbus = src[3] ? SBUS_NONE : src;
        return d;
    endfunction

    state_t     state_reg;
    ctl_t       cur_reg;
    logic [3:0] rep_cnt_reg;

    logic [3:0] in_op;
    logic [3:0] in_rep;
    logic       in_illegal;
    ctl_t       in_dec;

    assign in_op      = in_instr[OPC_HI:OPC_LO];
    assign in_rep     = in_instr[CONST_LO+3:CONST_LO];
    assign in_illegal = in_instr[DEST_HI] | ((in_op != OP_LDC) & in_instr[SRC_HI]);
    assign in_dec     = decode(in_instr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cur_reg     <= '0;
            rep_cnt_reg <= 4'd1;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            retired     <= '0;
            ctl_dest    <= DST_NONE;
            ctl_sbus    <= SBUS_NONE;
            ctl_address <= '0;
            ctl_alu     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (in_op == OP_REP) begin
                            rep_cnt_reg <= (in_rep == 4'd0) ? 4'd1 : in_rep;
                        end else if (in_op != OP_NOP) begin
                            // READ controls must be on the buses the cycle after the handshake.
                            cur_reg     <= in_dec;
                            state_reg   <= ST_READ;
                            in_ready    <= 1'b0;
                            busy        <= 1'b1;
                            ctl_dest    <= DST_NONE;
                            ctl_sbus    <= in_dec.sbus;
                            ctl_address <= in_dec.address;
                            ctl_alu     <= in_dec.alu;
                            if (in_illegal)
                                err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    state_reg   <= ST_WRITE;
                    ctl_dest    <= cur_reg.dest;
                    ctl_sbus    <= cur_reg.sbus;
                    ctl_address <= cur_reg.address;
                    ctl_alu     <= cur_reg.alu;
                end
                ST_WRITE: begin
                    retired  <= retired + CNT_W'(1);
                    ctl_dest <= DST_NONE;
                    if (rep_cnt_reg > 4'd1) begin
                        // Re-issue: S-bus/ALU selects stay put, only the write strobe drops.
                        rep_cnt_reg <= rep_cnt_reg - 4'd1;
                        state_reg   <= ST_READ;
                    end else begin
                        rep_cnt_reg <= 4'd1;
                        state_reg   <= ST_IDLE;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                        ctl_sbus    <= SBUS_NONE;
                        ctl_address <= '0;
                        ctl_alu     <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctl_sequencer.sv
// Directed bench for ctl_sequencer: hand-computed control values per cycle.
module tb_ctl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_instr;
    logic        in_ready;
    logic [3:0]  ctl_dest;
    logic [3:0]  ctl_sbus;
    logic [11:0] ctl_address;
    logic [3:0]  ctl_alu;
    logic        busy;
    logic        err;
    logic [15:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    ctl_sequencer #(.INSTR_W(24), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .ctl_dest    (ctl_dest),
        .ctl_sbus    (ctl_sbus),
        .ctl_address (ctl_address),
        .ctl_alu     (ctl_alu),
        .busy        (busy),
        .err         (err),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake; returns sampling the cycle right after the accepting edge.
    task automatic send(input logic [23:0] instr);
        check_eq("hs_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles from the first post-handshake cycle until in_ready returns.
    task automatic run_until_ready(input logic [3:0] d, input logic [3:0] alu,
                                   output int cyc, output int nd, output int nalu);
        cyc  = 1;
        nd   = 0;
        nalu = 0;
        while (!in_ready && cyc < 40) begin
            if (ctl_dest == d) nd++;
            if (ctl_alu != alu) nalu++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc, nd, nalu, hs, n4, n5;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        tick();
        tick();
        check_eq("rst_dest",    {28'd0, ctl_dest}, 32'hF);
        check_eq("rst_sbus",    {28'd0, ctl_sbus}, 32'hF);
        check_eq("rst_addr",    {20'd0, ctl_address}, 32'h0);
        check_eq("rst_alu",     {28'd0, ctl_alu}, 32'h0);
        check_eq("rst_busy",    {31'd0, busy}, 32'd0);
        check_eq("rst_err",     {31'd0, err}, 32'd0);
        check_eq("rst_retired", {16'd0, retired}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check_eq("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // MOV dest=3 src=5
        send(24'h135000);
        check_eq("mov_rd_sbus",  {28'd0, ctl_sbus}, 32'd5);
        check_eq("mov_rd_dest",  {28'd0, ctl_dest}, 32'hF);
        check_eq("mov_rd_alu",   {28'd0, ctl_alu}, 32'd1);
        check_eq("mov_rd_busy",  {31'd0, busy}, 32'd1);
        check_eq("mov_rd_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_eq("mov_wr_dest",  {28'd0, ctl_dest}, 32'd3);
        check_eq("mov_wr_sbus",  {28'd0, ctl_sbus}, 32'd5);
        tick();
        check_eq("mov_done_ready",   {31'd0, in_ready}, 32'd1);
        check_eq("mov_done_retired", {16'd0, retired}, 32'd1);
        check_eq("mov_done_busy",    {31'd0, busy}, 32'd0);

        // LDC dest=2 const=ABC
        send(24'h220ABC);
        check_eq("ldc_rd_sbus", {28'd0, ctl_sbus}, 32'd8);
        check_eq("ldc_rd_addr", {20'd0, ctl_address}, 32'hABC);
        tick();
        check_eq("ldc_wr_dest", {28'd0, ctl_dest}, 32'd2);
        check_eq("ldc_wr_addr", {20'd0, ctl_address}, 32'hABC);
        tick();
        check_eq("ldc_retired", {16'd0, retired}, 32'd2);

        // REP 3 then ALU op 4 dest=1 src=1
        send(24'hF00003);
        check_eq("rep_idle_busy",  {31'd0, busy}, 32'd0);
        check_eq("rep_idle_ready", {31'd0, in_ready}, 32'd1);
        send(24'h411000);
        run_until_ready(4'd1, 4'd4, cyc, nd, nalu);
        check_eq("rep_latency",  cyc, 32'd7);
        check_eq("rep_writes",   nd, 32'd3);
        check_eq("rep_alu_bad",  nalu, 32'd0);
        check_eq("rep_retired",  {16'd0, retired}, 32'd5);

        // Illegal dest=9 in MOV, then a legal MOV
        send(24'h190000);
        check_eq("ill_rd_err", {31'd0, err}, 32'd1);
        tick();
        check_eq("ill_wr_dest", {28'd0, ctl_dest}, 32'hF);
        tick();
        send(24'h132000);
        run_until_ready(4'd3, 4'd1, cyc, nd, nalu);
        check_eq("ill_err_sticky", {31'd0, err}, 32'd1);
        check_eq("ill_retired",    {16'd0, retired}, 32'd7);

        // in_valid held high; a different word is shown while busy and must be ignored
        hs = 0;
        n4 = 0;
        n5 = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_instr = in_ready ? 24'h146000 : 24'h156000;
            if (in_ready) hs++;
            tick();
            if (ctl_dest == 4'd4) n4++;
            if (ctl_dest == 4'd5) n5++;
        end
        in_valid = 1'b0;
        check_eq("b2b_handshakes", hs, 32'd3);
        check_eq("b2b_writes",     n4, 32'd3);
        check_eq("b2b_ignored",    n5, 32'd0);
        check_eq("b2b_retired",    {16'd0, retired}, 32'd10);

        // Reset during WRITE of a repeated instruction
        send(24'hF00002);
        send(24'h161000);
        tick();
        check_eq("arst_pre_dest", {28'd0, ctl_dest}, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dest",    {28'd0, ctl_dest}, 32'hF);
        check_eq("arst_busy",    {31'd0, busy}, 32'd0);
        check_eq("arst_retired", {16'd0, retired}, 32'd0);
        check_eq("arst_err",     {31'd0, err}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        send(24'h161000);
        run_until_ready(4'd6, 4'd1, cyc, nd, nalu);
        check_eq("post_rst_latency", cyc, 32'd3);
        check_eq("post_rst_writes",  nd, 32'd1);
        check_eq("post_rst_retired", {16'd0, retired}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
